draw_rect_char_16x16: RTL
=========================

Name: draw_rect_char_16x16

Overview:
- Text-overlay stage of the VGA pipeline. Places a 16x16-character text box, 128x256 px with 8x16 glyphs, at a fixed screen position.
- From incoming timing it generates the character address for char_rom_16x16 and the glyph row for the font ROM, then composites the returned glyph bits onto the pixel stream.
- Adds a typewriter reveal: characters become visible one at a time, one per REVEAL_FRAMES frames. The reveal restarts whenever the text mode changes.

Parameters:
XPOS, 100, left edge of text box, in pixels.
YPOS, 100, top edge of text box, in lines.
TEXT_COLOR, 12'hFFF, RGB444 colour of lit glyph pixels.
REVEAL_FRAMES, 2, frames per revealed character; 0 = whole text visible immediately.

Ports:
pclk  in  1  pixel clock; single clock domain.
rst  in  1  asynchronous, active-high reset.
mode  in  1  text page select, the same signal that drives char_rom_16x16; any change restarts the reveal.
hcount_in  in  11  horizontal pixel counter.
hsync_in  in  1  horizontal sync.
hblnk_in  in  1  horizontal blanking.
vcount_in  in  11  vertical line counter.
vsync_in  in  1  vertical sync.
vblnk_in  in  1  vertical blanking.
rgb_in  in  12  upstream pixel colour.
char_pixels  in  8  glyph row from the synchronous font ROM; bit 7 = leftmost pixel.
char_yx  out  8  {char_y, char_x} address to char_rom_16x16.
char_line  out  4  glyph row index to the font ROM.
hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  timing delayed to match rgb_out.
rgb_out  out  12  composited pixel colour.

Behaviour:
- Reset (async, rst=1): every output register 0, all pipeline stages 0, reveal_cnt=0, frame_cnt=0, mode_d and vsync_d equal 0.
- Box membership: in_box = (XPOS <= hcount < XPOS+128) and (YPOS <= vcount < YPOS+256), using unsigned 11-bit compares. hrel = hcount-XPOS; vrel = vcount-YPOS.
- Stage 1 (registered):
  - char_yx = {vrel[7:4], hrel[6:3]}; char_line = vrel[3:0].
  - Both outputs are 0 when the input pixel is not in_box.
  - Timing, rgb, in_box and hrel[2:0] are delayed alongside (d1).
- Stage 2: the font ROM is external and registers {char_code, char_line}, so char_pixels is aligned with the d2 copies. The block delays timing, rgb, in_box, hrel[2:0] and char_yx to d2.
- Stage 3 (output register):
  - lit = in_box_d2 & ~hblnk_d2 & ~vblnk_d2 & char_pixels[7-hrel_d2] & (char_yx_d2 < reveal_cnt).
  - rgb_out = lit ? TEXT_COLOR : rgb_d2.
  - Timing outputs = d2 copies.
  - Total latency input -> output is 3 pclk cycles, identical for every output except char_yx/char_line (1 cycle).
- Glyph background is transparent: unlit pixels pass rgb through unchanged, both inside and outside the box.
- Reveal FSM:
  - frame_tick = vsync_in & ~vsync_d (rising edge of the registered copy).
  - frame_cnt counts 0..REVEAL_FRAMES-1 on frame_tick. On wrap, reveal_cnt increments (9 bits), saturating at 256 (all 256 characters visible).
  - mode_change = mode != mode_d. It forces reveal_cnt=0 and frame_cnt=0 and has priority over a simultaneous frame_tick.
  - REVEAL_FRAMES=0: reveal_cnt is held at 256 permanently, including out of reset; mode_change has no visible effect.
  - reveal_cnt changes only on frame_tick or mode_change.
- Boundaries:
  - Pixel at h=XPOS+127 is in the box; h=XPOS+128 and v=YPOS+256 are outside (pass-through).
  - Boxes exceeding the 11-bit screen range are unsupported; XPOS+128 and YPOS+256 must be below 2048.
- Reset asserted mid-frame: outputs go to 0 immediately. After release the pipeline refills, producing valid output 3 cycles after the first sampled input, and the reveal restarts from 0.

Test Plan:
- Reset: assert rst with random inputs -> all outputs 0 within the same cycle, held while rst=1.
- Address generation: hcount=XPOS+43, vcount=YPOS+39 -> one cycle later char_yx=8'h25, char_line=4'h7. Moving to hcount=XPOS-1 gives char_yx=0, char_line=0.
- Latency/compositing: REVEAL_FRAMES=0, char_pixels=8'h80 in stage alignment.
  - Pixel at hrel=0 inside box, no blanking -> rgb_out=12'hFFF exactly 3 cycles after input.
  - hrel=1 -> rgb_out=rgb_in of 3 cycles earlier.
  - hblnk_in=1 -> pass-through.
- Reveal: REVEAL_FRAMES=2, 6 vsync rising edges after reset -> reveal_cnt=3. Character 8'h02 with lit bits is drawn; 8'h03 is not.
- Mode restart: toggle mode after 10 frames, same cycle as a vsync rise -> reveal_cnt=0 next cycle, no text drawn. Exactly 2 further frames bring reveal_cnt to 1.
- Saturation/edges: 600 frames with REVEAL_FRAMES=2 -> reveal_cnt=256, character 8'hFF drawn. Pixels at h=XPOS+128 and v=YPOS+256 are pass-through even when char_pixels=8'hFF.

Source files
------------

// File: rtl/draw_rect_char_16x16.sv
// Text-overlay stage: 16x16-character box (8x16 glyphs) at a fixed
// screen position, with a per-character typewriter reveal. The font ROM
// is external and synchronous, so pixel data is delayed by two stages
// before compositing in the third (output) register.
module draw_rect_char_16x16 #(
  parameter int          XPOS          = 100,
  parameter int          YPOS          = 100,
  parameter logic [11:0] TEXT_COLOR    = 12'hFFF,
  parameter int          REVEAL_FRAMES = 2
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        mode,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [7:0]  char_pixels,
  output logic [7:0]  char_yx,
  output logic [3:0]  char_line,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [10:0] X_LO       = 11'(XPOS);
  localparam logic [10:0] X_HI       = 11'(XPOS + 128);
  localparam logic [10:0] Y_LO       = 11'(YPOS);
  localparam logic [10:0] Y_HI       = 11'(YPOS + 256);
  localparam logic [8:0]  REVEAL_ALL = 9'd256;
  localparam logic [15:0] FC_MAX     = (REVEAL_FRAMES == 0) ? 16'd0 : 16'(REVEAL_FRAMES - 1);
  // With no reveal delay the whole text is visible even straight out of reset.
  localparam logic [8:0]  REVEAL_RST = (REVEAL_FRAMES == 0) ? REVEAL_ALL : 9'd0;

  // Timing bundle layout: {hcount[25:15], hsync[14], hblnk[13], vcount[12:2], vsync[1], vblnk[0]}
  logic [25:0] tim_in_s, tim_d1_q, tim_d2_q, tim_out_q;
  logic [11:0] rgb_d1_q, rgb_d2_q, rgb_out_q, rgb_out_d;
  logic        in_box_s, in_box_d1_q, in_box_d2_q;
  logic [2:0]  hrel_d1_q, hrel_d2_q;
  logic [10:0] hrel_s, vrel_s;
  logic [7:0]  char_yx_d, char_yx_q, char_yx_d2_q;
  logic [3:0]  char_line_d, char_line_q;
  logic        lit_s;
  logic        vsync_q, mode_q;
  logic        frame_tick_s, mode_change_s;
  logic [15:0] frame_cnt_d, frame_cnt_q;
  logic [8:0]  reveal_cnt_d, reveal_cnt_q;

  assign tim_in_s = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};

  // Box membership, box-relative coordinates and the character ROM address.
  always_comb begin
    hrel_s   = hcount_in - X_LO;
    vrel_s   = vcount_in - Y_LO;
    in_box_s = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
               (vcount_in >= Y_LO) && (vcount_in < Y_HI);
    if (in_box_s) begin
      char_yx_d   = {vrel_s[7:4], hrel_s[6:3]};
      char_line_d = vrel_s[3:0];
    end else begin
      char_yx_d   = 8'd0;
      char_line_d = 4'd0;
    end
  end

  // Pixel pipeline: stage 1 (address out), stage 2 (font ROM latency), stage 3 (output).
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      char_yx_q    <= 8'd0;
      char_line_q  <= 4'd0;
      tim_d1_q     <= 26'd0;
      rgb_d1_q     <= 12'd0;
      in_box_d1_q  <= 1'b0;
      hrel_d1_q    <= 3'd0;
      tim_d2_q     <= 26'd0;
      rgb_d2_q     <= 12'd0;
      in_box_d2_q  <= 1'b0;
      hrel_d2_q    <= 3'd0;
      char_yx_d2_q <= 8'd0;
      tim_out_q    <= 26'd0;
      rgb_out_q    <= 12'd0;
    end else begin
      char_yx_q    <= char_yx_d;
      char_line_q  <= char_line_d;
      tim_d1_q     <= tim_in_s;
      rgb_d1_q     <= rgb_in;
      in_box_d1_q  <= in_box_s;
      hrel_d1_q    <= hrel_s[2:0];
      tim_d2_q     <= tim_d1_q;
      rgb_d2_q     <= rgb_d1_q;
      in_box_d2_q  <= in_box_d1_q;
      hrel_d2_q    <= hrel_d1_q;
      char_yx_d2_q <= char_yx_q;
      tim_out_q    <= tim_d2_q;
      rgb_out_q    <= rgb_out_d;
    end
  end

  // Composite: a glyph pixel is lit only inside the box, outside blanking,
  // and only for characters the reveal has already reached.
  always_comb begin
    lit_s = in_box_d2_q & ~tim_d2_q[13] & ~tim_d2_q[0] &
            char_pixels[3'd7 - hrel_d2_q] &
            ({1'b0, char_yx_d2_q} < reveal_cnt_q);
    if (lit_s) begin
      rgb_out_d = TEXT_COLOR;
    end else begin
      rgb_out_d = rgb_d2_q;
    end
  end

  assign frame_tick_s  = vsync_in & ~vsync_q;
  assign mode_change_s = (mode != mode_q);

  // Reveal next state: mode change restarts, frame wrap advances, saturating at 256.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    reveal_cnt_d = reveal_cnt_q;
    if (REVEAL_FRAMES == 0) begin
      frame_cnt_d  = 16'd0;
      reveal_cnt_d = REVEAL_ALL;
    end else if (mode_change_s) begin
      frame_cnt_d  = 16'd0;
      reveal_cnt_d = 9'd0;
    end else if (frame_tick_s) begin
      if (frame_cnt_q == FC_MAX) begin
        frame_cnt_d = 16'd0;
        if (reveal_cnt_q != REVEAL_ALL) begin
          reveal_cnt_d = reveal_cnt_q + 9'd1;
        end else begin
          reveal_cnt_d = reveal_cnt_q;
        end
      end else begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end else begin
      frame_cnt_d  = frame_cnt_q;
      reveal_cnt_d = reveal_cnt_q;
    end
  end

  // Reveal state and edge-detect history registers.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      mode_q       <= 1'b0;
      frame_cnt_q  <= 16'd0;
      reveal_cnt_q <= REVEAL_RST;
    end else begin
      vsync_q      <= vsync_in;
      mode_q       <= mode;
      frame_cnt_q  <= frame_cnt_d;
      reveal_cnt_q <= reveal_cnt_d;
    end
  end

  assign char_yx    = char_yx_q;
  assign char_line  = char_line_q;
  assign hcount_out = tim_out_q[25:15];
  assign hsync_out  = tim_out_q[14];
  assign hblnk_out  = tim_out_q[13];
  assign vcount_out = tim_out_q[12:2];
  assign vsync_out  = tim_out_q[1];
  assign vblnk_out  = tim_out_q[0];
  assign rgb_out    = rgb_out_q;

endmodule
